// File: rtl/gb_cpu_io_responder.sv
// CPU-side I/O responder: interrupt flag (IF), interrupt enable (IE) and HRAM,
// with zero-latency reads and edge-detected interrupt requests.
module gb_cpu_io_responder #(
   parameter int IF_UNUSED_ONES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] addr_i,
   input  logic [7:0]  data_i,
   input  logic        wr_en_i,
   output logic [7:0]  data_o,
   output logic        sel_o,
   input  logic [4:0]  irq_i,
   input  logic        clear_interrupt_flag_i,
   output logic [7:0]  reg_IF_o,
   output logic [7:0]  reg_IE_o
);

   localparam logic [2:0] IF_PAD = (IF_UNUSED_ONES != 0) ? 3'b111 : 3'b000;

   logic [4:0] if_reg;
   logic [4:0] if_next;
   logic [7:0] ie_reg;
   logic [4:0] irq_prev_reg;
   logic [7:0] hram_mem [0:127];

   logic       hit_if;
   logic       hit_ie;
   logic       hit_hram;
   logic       wr_if;
   logic       wr_ie;
   logic       wr_hram;
   logic [4:0] edge_mask;
   logic [4:0] clr_mask;
   logic [4:0] pending_below;

   // 0xFFFF shares the HRAM page but belongs to IE, so it is carved out here.
   assign hit_if   = (addr_i == 16'hFF0F);
   assign hit_ie   = (addr_i == 16'hFFFF);
   assign hit_hram = (addr_i[15:7] == 9'h1FF) && (addr_i[6:0] != 7'h7F);
   assign sel_o    = hit_if | hit_ie | hit_hram;

   assign wr_if   = wr_en_i & hit_if;
   assign wr_ie   = wr_en_i & hit_ie;
   assign wr_hram = wr_en_i & hit_hram;

   assign edge_mask = irq_i & ~irq_prev_reg;

   // Priority chain: a bit is cleared only if no lower-numbered flag is pending.
   assign pending_below[0] = 1'b0;
   generate
      for (genvar gi = 1; gi < 5; gi++) begin : g_below
         assign pending_below[gi] = pending_below[gi-1] | if_reg[gi-1];
      end
      for (genvar gi = 0; gi < 5; gi++) begin : g_clr
         assign clr_mask[gi] = clear_interrupt_flag_i & if_reg[gi] & ~pending_below[gi];
      end
   endgenerate

   assign if_next = ((wr_if ? data_i[4:0] : if_reg) & ~clr_mask) | edge_mask;

   always_ff @(posedge clk) begin
      if (reset) begin
         if_reg       <= 5'd0;
         ie_reg       <= 8'h00;
         irq_prev_reg <= irq_i;
      end else begin
         if_reg       <= if_next;
         irq_prev_reg <= irq_i;
         if (wr_ie) begin
            ie_reg <= data_i;
         end
      end
   end

   // HRAM has no reset so that its contents survive a mid-operation reset.
   always_ff @(posedge clk) begin
      if (!reset && wr_hram) begin
         hram_mem[addr_i[6:0]] <= data_i;
      end
   end

   always_comb begin
      data_o = 8'hFF;
      if (hit_if) begin
         data_o = {IF_PAD, if_reg};
      end else if (hit_ie) begin
         data_o = ie_reg;
      end else if (hit_hram) begin
         data_o = hram_mem[addr_i[6:0]];
      end
   end

   assign reg_IF_o = {3'b000, if_reg};
   assign reg_IE_o = ie_reg;

endmodule

// File: tb/tb_gb_cpu_io_responder.sv
// Bench for gb_cpu_io_responder: directed scenarios with literal expectations plus
// a per-cycle comparison against a rule-level model of IF/IE/HRAM.
module tb_gb_cpu_io_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] addr_i;
   logic [7:0]  data_i;
   logic        wr_en_i;
   logic [7:0]  data_o;
   logic        sel_o;
   logic [4:0]  irq_i;
   logic        clear_interrupt_flag_i;
   logic [7:0]  reg_IF_o;
   logic [7:0]  reg_IE_o;

   int tests = 0;
   int fails = 0;

   gb_cpu_io_responder #(.IF_UNUSED_ONES(1)) dut (
      .clk                    (clk),
      .reset                  (reset),
      .addr_i                 (addr_i),
      .data_i                 (data_i),
      .wr_en_i                (wr_en_i),
      .data_o                 (data_o),
      .sel_o                  (sel_o),
      .irq_i                  (irq_i),
      .clear_interrupt_flag_i (clear_interrupt_flag_i),
      .reg_IF_o               (reg_IF_o),
      .reg_IE_o               (reg_IE_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [4:0] if_m;
   logic [7:0] ie_m;
   logic [4:0] prev_m;
   logic [7:0] hram_m [0:127];
   bit         hram_v [0:127];
   bit         model_ok = 0;

   function automatic logic [4:0] model_if_next(input logic [4:0] cur, input logic [4:0] irq,
                                                 input logic [4:0] prev, input bit wr,
                                                 input logic [4:0] wd, input bit clr);
      logic [4:0] r;
      int lo = -1;
      for (int b = 0; b < 5; b++) if (lo < 0 && cur[b]) lo = b;
      for (int b = 0; b < 5; b++) begin
         r[b] = wr ? wd[b] : cur[b];
         if (clr && b == lo) r[b] = 1'b0;
         if (irq[b] && !prev[b]) r[b] = 1'b1;
      end
      return r;
   endfunction

   function automatic bit is_hram(input logic [15:0] a);
      return (a >= 16'hFF80) && (a <= 16'hFFFE);
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         if_m     <= 5'd0;
         ie_m     <= 8'h00;
         prev_m   <= irq_i;
         model_ok <= 1;
      end else if (model_ok) begin
         if_m   <= model_if_next(if_m, irq_i, prev_m, wr_en_i && addr_i == 16'hFF0F,
                                 data_i[4:0], clear_interrupt_flag_i);
         prev_m <= irq_i;
         if (wr_en_i && addr_i == 16'hFFFF) ie_m <= data_i;
         if (wr_en_i && is_hram(addr_i)) begin
            hram_m[addr_i[6:0]] <= data_i;
            hram_v[addr_i[6:0]] <= 1;
         end
      end
   end

   // Per-cycle compare, sampled mid-cycle on the falling edge.
   always @(negedge clk) begin
      if (model_ok) begin
         chk("reg_IF_o", {24'd0, reg_IF_o}, {27'd0, if_m});
         chk("reg_IE_o", {24'd0, reg_IE_o}, {24'd0, ie_m});
         chk("sel_o", {31'd0, sel_o},
             {31'd0, (addr_i == 16'hFF0F) || (addr_i >= 16'hFF80)});
         if (addr_i == 16'hFF0F)
            chk("data_o IF", {24'd0, data_o}, {24'd0, 3'b111, if_m});
         else if (addr_i == 16'hFFFF)
            chk("data_o IE", {24'd0, data_o}, {24'd0, ie_m});
         else if (is_hram(addr_i)) begin
            if (hram_v[addr_i[6:0]])
               chk("data_o HRAM", {24'd0, data_o}, {24'd0, hram_m[addr_i[6:0]]});
         end else
            chk("data_o unmapped", {24'd0, data_o}, 32'hFF);
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_en_i = 0;
      clear_interrupt_flag_i = 0;
   endtask

   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      addr_i = a; data_i = d; wr_en_i = 1;
      step();
      wr_en_i = 0;
   endtask

   task automatic peek(input string name, input logic [15:0] a,
                       input logic [7:0] exp, input logic exp_sel);
      addr_i = a; wr_en_i = 0;
      #1;
      chk(name, {24'd0, data_o}, {24'd0, exp});
      chk({name, " sel"}, {31'd0, sel_o}, {31'd0, exp_sel});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 128; i++) hram_v[i] = 0;
      reset = 1; addr_i = 16'h0000; data_i = 8'h00; irq_i = 5'd0; idle();
      step(); step();
      chk("reset IF", {24'd0, reg_IF_o}, 32'h00);
      chk("reset IE", {24'd0, reg_IE_o}, 32'h00);
      reset = 0;

      // HRAM write/read and unmapped read
      wr(16'hFF80, 8'hA5);
      wr(16'hFFFE, 8'h3C);
      peek("hram FF80", 16'hFF80, 8'hA5, 1'b1);
      peek("hram FFFE", 16'hFFFE, 8'h3C, 1'b1);
      peek("unmapped FF7F", 16'hFF7F, 8'hFF, 1'b0);

      // same-cycle read of IE returns the old value
      addr_i = 16'hFFFF; data_i = 8'h12; wr_en_i = 1; #1;
      chk("IE same-cycle old", {24'd0, data_o}, 32'h00);
      step(); wr_en_i = 0;
      chk("IE after write", {24'd0, reg_IE_o}, 32'h12);

      // single edge on irq[2], held high
      irq_i = 5'b00100; step();
      chk("irq2 edge", {24'd0, reg_IF_o}, 32'h04);
      repeat (4) step();
      chk("irq2 held", {24'd0, reg_IF_o}, 32'h04);
      peek("IF bus read", 16'hFF0F, 8'hE4, 1'b1);
      wr(16'hFF0F, 8'h00);
      step();
      chk("IF write0 held line", {24'd0, reg_IF_o}, 32'h00);
      irq_i = 5'd0; step();

      // priority clears
      wr(16'hFF0F, 8'h1F);
      clear_interrupt_flag_i = 1;
      step(); chk("clear 1", {24'd0, reg_IF_o}, 32'h1E);
      step(); chk("clear 2", {24'd0, reg_IF_o}, 32'h1C);
      step(); chk("clear 3", {24'd0, reg_IF_o}, 32'h18);
      idle();

      // set wins over clear
      wr(16'hFF0F, 8'h01);
      clear_interrupt_flag_i = 1; irq_i = 5'b00001;
      step(); idle(); irq_i = 5'd0;
      chk("set wins", {24'd0, reg_IF_o}, 32'h01);

      // write + clear: mask from pre-write IF
      wr(16'hFF0F, 8'h03);
      addr_i = 16'hFF0F; data_i = 8'h10; wr_en_i = 1; clear_interrupt_flag_i = 1;
      step(); idle();
      chk("write+clear", {24'd0, reg_IF_o}, 32'h10);

      // reset with lines held high
      wr(16'hFFFF, 8'hFF);
      wr(16'hFF0F, 8'h1F);
      irq_i = 5'h1F; reset = 1;
      step(); step();
      reset = 0;
      step();
      chk("post-reset IF", {24'd0, reg_IF_o}, 32'h00);
      chk("post-reset IE", {24'd0, reg_IE_o}, 32'h00);
      peek("hram kept", 16'hFF80, 8'hA5, 1'b1);
      irq_i = 5'd0; step();

      // pseudo-random traffic checked by the model each cycle
      for (int n = 0; n < 400; n++) begin
         case ($urandom_range(0, 4))
            0: addr_i = 16'hFF0F;
            1: addr_i = 16'hFFFF;
            2: addr_i = 16'hFF80 + 16'($urandom_range(0, 127));
            3: addr_i = 16'hFF00 + 16'($urandom_range(0, 127));
            default: addr_i = 16'($urandom);
         endcase
         data_i = 8'($urandom);
         wr_en_i = ($urandom_range(0, 2) == 0);
         clear_interrupt_flag_i = ($urandom_range(0, 2) == 0);
         irq_i = 5'($urandom);
         reset = ($urandom_range(0, 60) == 0);
         step();
      end
      reset = 0; idle(); step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/gb_cpu_io_responder.md
GB_CPU_IO_RESPONDER -- requirements
Module: gb_cpu_io_responder

Interface
REQ-001 The block SHALL have parameter IF_UNUSED_ONES, default 1, meaning IF bits 7:5 read back as 1 on the bus (0 when the parameter is 0).
REQ-002 The block SHALL have port clk, input, 1 bit, the machine (M) clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, synchronous, active-high.
REQ-004 The block SHALL have port addr_i, input, 16 bits, the CPU address bus.
REQ-005 The block SHALL have port data_i, input, 8 bits, the CPU write data.
REQ-006 The block SHALL have port wr_en_i, input, 1 bit, high when the CPU drives the data bus (write cycle).
REQ-007 The block SHALL have port data_o, output, 8 bits, the read data returned to the CPU.
REQ-008 The block SHALL have port sel_o, output, 1 bit, high when addr_i hits a location owned by this block.
REQ-009 The block SHALL have port irq_i, input, 5 bits, the peripheral request lines: bit0 VBlank, bit1 STAT, bit2 Timer, bit3 Serial, bit4 Joypad.
REQ-010 The block SHALL have port clear_interrupt_flag_i, input, 1 bit, the CPU request to clear the highest-priority pending flag.
REQ-011 The block SHALL have port reg_IF_o, output, 8 bits, the interrupt flag register to the CPU, with bits 7:5 always 0.
REQ-012 The block SHALL have port reg_IE_o, output, 8 bits, the interrupt enable register to the CPU.

Function
REQ-013 The address map SHALL be: 0xFF0F is IF (bits 4:0 stored); 0xFF80-0xFFFE is HRAM (127 x 8 bits, index addr_i[6:0]); 0xFFFF is IE (8 bits stored).
REQ-014 sel_o SHALL be combinational from addr_i and high exactly for the addresses in REQ-013.
REQ-015 Reads SHALL be combinational with zero latency: data_o is valid in the same cycle addr_i is presented, because the CPU samples data at the closing clock edge.
REQ-016 data_o for IF SHALL be {IF_UNUSED_ONES ? 3'b111 : 3'b000, IF[4:0]}; for IE it SHALL be IE; for HRAM it SHALL be the addressed byte; for unmapped addresses it SHALL be 0xFF.
REQ-017 A write SHALL take effect at the clock edge ending a cycle with wr_en_i=1 and sel_o=1; a write to an unmapped address SHALL change no state.
REQ-018 The register update SHALL be next_IF = ((wr_IF ? data_i[4:0] : IF) & ~clr_mask) | edge_mask; this equation defines the result of every combination of simultaneous events.
REQ-019 edge_mask SHALL be irq_i & ~irq_prev, where irq_prev is irq_i registered every cycle; only a 0->1 transition sets a flag, and a line held high sets it once.
REQ-020 clr_mask SHALL be one-hot on the lowest-numbered set bit of the current (pre-write) IF[4:0] when clear_interrupt_flag_i=1, else 0.
REQ-021 clr_mask SHALL ignore IE, matching the vector priority the CPU uses.
REQ-022 When clear_interrupt_flag_i=1 and IF[4:0]=0, no bit SHALL change.
REQ-023 A new edge on a bit SHALL win over a clear or a write-0 of that bit in the same cycle, so no request is lost.
REQ-024 clear_interrupt_flag_i SHALL clear at most one bit per cycle; holding it high for N cycles clears up to N bits in priority order.
REQ-025 IE SHALL be written with data_i[7:0] when 0xFFFF is written; IE SHALL change by no other means.
REQ-026 reg_IF_o SHALL be {3'b000, IF[4:0]} and reg_IE_o SHALL be IE, both driven directly from registers with no combinational path from inputs.
REQ-027 A write SHALL be visible on data_o, reg_IF_o and reg_IE_o from the cycle after the write edge; a same-cycle read returns the old value.

Reset
REQ-028 In reset, IF[4:0] SHALL load 0 and IE SHALL load 0x00, so reg_IF_o=0x00 and reg_IE_o=0x00 in the first cycle after reset.
REQ-029 In reset, irq_prev SHALL load the current irq_i, so a line already high at reset release produces no edge.
REQ-030 Reset SHALL take priority over writes, edges and clears in the same cycle.
REQ-031 Reset SHALL NOT initialise HRAM; its contents are undefined until written, and reset mid-operation SHALL leave already-written HRAM bytes unchanged.

Verification
REQ-032 Reset, then write 0xA5 to 0xFF80 and 0x3C to 0xFFFE, then read both -> data_o=0xA5 and 0x3C, sel_o=1; read 0xFF7F -> data_o=0xFF, sel_o=0.
REQ-033 Pulse irq_i[2] 0->1 and hold it high for 5 cycles -> IF bit2 set once, reg_IF_o=0x04, bus read of 0xFF0F=0xE4; write 0x00 to 0xFF0F while irq_i[2] stays high -> IF stays 0x00.
REQ-034 Set IF=0x1F by writing 0xFF0F, then assert clear_interrupt_flag_i for 3 cycles -> reg_IF_o reads 0x1E, then 0x1C, then 0x18.
REQ-035 IF=0x01, and in the same cycle clear_interrupt_flag_i=1 with a rising edge on irq_i[0] -> reg_IF_o=0x01 (set wins).
REQ-036 IF=0x03, and in the same cycle write 0x10 to 0xFF0F with clear_interrupt_flag_i=1 -> reg_IF_o=0x10 (clr_mask=0x01 from pre-write IF).
REQ-037 Write IE=0xFF and IF=0x1F, then reset with irq_i=0x1F held high -> after reset release reg_IF_o=0x00 and reg_IE_o=0x00 with no re-trigger, and the HRAM byte written before reset reads back unchanged.
